// File: rtl/ps2_kbd_ascii.sv
// Set-2 scancode to ASCII translator with Shift/Ctrl/Caps tracking and a character FIFO.
// Optional build macro PS2_KBD_CTRL_CODES_EN: Ctrl+letter pushes the control code (letter & 0x1F).
// Handshake: the head character transfers on a clk_25mhz edge where ascii_valid && ascii_ready;
// ascii_valid never drops and ascii never changes until that transfer happens.
module ps2_kbd_ascii #(
  parameter int FIFO_DEPTH = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_25mhz,
  input  logic          reset_n,
  input  logic [7:0]    scancode,
  input  logic          key_valid,
  input  logic          extended,
  input  logic          released,
  output logic [7:0]    ascii,
  output logic          ascii_valid,
  input  logic          ascii_ready,
  output logic          caps_lock,
  output logic          overflow,
  output logic [LW-1:0] fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {K_NONE, K_CHAR, K_SHL, K_SHR, K_CTRL, K_CAPS} kind_t;
  typedef struct packed {
    logic       mapped;
    logic       letter;
    logic [7:0] lo;
    logic [7:0] hi;
  } lut_t;

  function automatic lut_t lut(input logic [7:0] c);
    lut_t r;
    r = '{mapped: 1'b1, letter: 1'b0, lo: 8'h00, hi: 8'h00};
    case (c)
      8'h1C: r.lo = "a";  8'h32: r.lo = "b";  8'h21: r.lo = "c";  8'h23: r.lo = "d";
      8'h24: r.lo = "e";  8'h2B: r.lo = "f";  8'h34: r.lo = "g";  8'h33: r.lo = "h";
      8'h43: r.lo = "i";  8'h3B: r.lo = "j";  8'h42: r.lo = "k";  8'h4B: r.lo = "l";
      8'h3A: r.lo = "m";  8'h31: r.lo = "n";  8'h44: r.lo = "o";  8'h4D: r.lo = "p";
      8'h15: r.lo = "q";  8'h2D: r.lo = "r";  8'h1B: r.lo = "s";  8'h2C: r.lo = "t";
      8'h3C: r.lo = "u";  8'h2A: r.lo = "v";  8'h1D: r.lo = "w";  8'h22: r.lo = "x";
      8'h35: r.lo = "y";  8'h1A: r.lo = "z";
      8'h16: begin r.lo = "1"; r.hi = "!"; end
      8'h1E: begin r.lo = "2"; r.hi = "@"; end
      8'h26: begin r.lo = "3"; r.hi = "#"; end
      8'h25: begin r.lo = "4"; r.hi = "$"; end
      8'h2E: begin r.lo = "5"; r.hi = "%"; end
      8'h36: begin r.lo = "6"; r.hi = "^"; end
      8'h3D: begin r.lo = "7"; r.hi = "&"; end
      8'h3E: begin r.lo = "8"; r.hi = "*"; end
      8'h46: begin r.lo = "9"; r.hi = "("; end
      8'h45: begin r.lo = "0"; r.hi = ")"; end
      8'h4E: begin r.lo = "-"; r.hi = "_"; end
      8'h55: begin r.lo = "="; r.hi = "+"; end
      8'h54: begin r.lo = "["; r.hi = "{"; end
      8'h5B: begin r.lo = "]"; r.hi = "}"; end
      8'h5D: begin r.lo = "\\"; r.hi = "|"; end
      8'h4C: begin r.lo = ";"; r.hi = ":"; end
      8'h52: begin r.lo = "'"; r.hi = "\""; end
      8'h41: begin r.lo = ","; r.hi = "<"; end
      8'h49: begin r.lo = "."; r.hi = ">"; end
      8'h4A: begin r.lo = "/"; r.hi = "?"; end
      8'h0E: begin r.lo = 8'h60; r.hi = 8'h7E; end
      8'h29: begin r.lo = 8'h20; r.hi = 8'h20; end
      8'h5A: begin r.lo = 8'h0D; r.hi = 8'h0D; end
      8'h66: begin r.lo = 8'h08; r.hi = 8'h08; end
      8'h0D: begin r.lo = 8'h09; r.hi = 8'h09; end
      8'h76: begin r.lo = 8'h1B; r.hi = 8'h1B; end
      default: r.mapped = 1'b0;
    endcase
    // Letter entries only fill the lowercase slot; uppercase differs by bit 5.
    if (r.lo >= "a" && r.lo <= "z") begin
      r.letter = 1'b1;
      r.hi     = r.lo ^ 8'h20;
    end
    return r;
  endfunction

  logic          kv_q, kv_d;
  logic          s0_valid_q, s0_valid_d, s0_ext_q, s0_ext_d, s0_rel_q, s0_rel_d;
  logic [7:0]    s0_code_q, s0_code_d;
  kind_t         s1_kind_q, s1_kind_d;
  logic          s1_rel_q, s1_rel_d, s1_letter_q, s1_letter_d;
  logic [6:0]    s1_lo_q, s1_lo_d, s1_hi_q, s1_hi_d;
  logic          shl_q, shl_d, shr_q, shr_d, ctrl_q, ctrl_d;
  logic          caps_q, caps_d, caps_held_q, caps_held_d, ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [6:0]    mem_d [FIFO_DEPTH];
  logic          push, pop, full, do_push, shift;
  logic [6:0]    ch;
  lut_t          lk;

  always_comb begin
    kv_d       = key_valid;
    s0_valid_d = key_valid & ~kv_q;
    s0_ext_d   = s0_ext_q;
    s0_rel_d   = s0_rel_q;
    s0_code_d  = s0_code_q;
    if (s0_valid_d) begin
      s0_ext_d  = extended;
      s0_rel_d  = released;
      s0_code_d = scancode;
    end
  end

  always_comb begin
    lk = lut(s0_code_q);
    if (s0_ext_q) begin
      lk.mapped = (s0_code_q == 8'h5A) || (s0_code_q == 8'h4A);
      if (s0_code_q == 8'h4A) lk.hi = lk.lo;
    end
    s1_kind_d   = K_NONE;
    s1_rel_d    = s0_rel_q;
    s1_letter_d = lk.letter;
    s1_lo_d     = lk.lo[6:0];
    s1_hi_d     = lk.hi[6:0];
    if (s0_valid_q) begin
      if (!s0_ext_q && s0_code_q == 8'h12)      s1_kind_d = K_SHL;
      else if (!s0_ext_q && s0_code_q == 8'h59) s1_kind_d = K_SHR;
      else if (s0_code_q == 8'h14)              s1_kind_d = K_CTRL;
      else if (!s0_ext_q && s0_code_q == 8'h58) s1_kind_d = K_CAPS;
      else if (lk.mapped && !s0_rel_q)          s1_kind_d = K_CHAR;
    end
  end

  always_comb begin
    shl_d       = shl_q;
    shr_d       = shr_q;
    ctrl_d      = ctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    push        = 1'b0;
    case (s1_kind_q)
      K_SHL:  shl_d  = ~s1_rel_q;
      K_SHR:  shr_d  = ~s1_rel_q;
      K_CTRL: ctrl_d = ~s1_rel_q;
      K_CAPS: begin
        // caps_held suppresses re-toggling on typematic repeats
        if (s1_rel_q) caps_held_d = 1'b0;
        else if (!caps_held_q) begin
          caps_d      = ~caps_q;
          caps_held_d = 1'b1;
        end
      end
      K_CHAR:  push = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    shift = shl_q | shr_q;
    if (s1_letter_q) ch = (shift ^ caps_q) ? s1_hi_q : s1_lo_q;
    else             ch = shift ? s1_hi_q : s1_lo_q;
`ifdef PS2_KBD_CTRL_CODES_EN
    if (s1_letter_q && ctrl_q) ch = s1_lo_q & 7'h1F;
`endif
  end

  always_comb begin
    full     = (count_q == LW'(FIFO_DEPTH));
    pop      = (count_q != '0) && ascii_ready;
    do_push  = push && (!full || pop);
    ovf_d    = ovf_q | (push && full && !pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop)      count_d = count_q + LW'(1);
    else if (pop && !do_push) count_d = count_q - LW'(1);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = ch;
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      kv_q <= 1'b0; s0_valid_q <= 1'b0; s0_ext_q <= 1'b0; s0_rel_q <= 1'b0;
      s0_code_q <= 8'h00; s1_kind_q <= K_NONE; s1_rel_q <= 1'b0; s1_letter_q <= 1'b0;
      s1_lo_q <= 7'h00; s1_hi_q <= 7'h00;
      shl_q <= 1'b0; shr_q <= 1'b0; ctrl_q <= 1'b0; caps_q <= 1'b0; caps_held_q <= 1'b0;
      ovf_q <= 1'b0; wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
    end else begin
      kv_q <= kv_d; s0_valid_q <= s0_valid_d; s0_ext_q <= s0_ext_d; s0_rel_q <= s0_rel_d;
      s0_code_q <= s0_code_d; s1_kind_q <= s1_kind_d; s1_rel_q <= s1_rel_d;
      s1_letter_q <= s1_letter_d; s1_lo_q <= s1_lo_d; s1_hi_q <= s1_hi_d;
      shl_q <= shl_d; shr_q <= shr_d; ctrl_q <= ctrl_d; caps_q <= caps_d;
      caps_held_q <= caps_held_d; ovf_q <= ovf_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates what is visible.
  always_ff @(posedge clk_25mhz) mem_q <= mem_d;

  assign ascii       = (count_q != '0) ? {1'b0, mem_q[rd_ptr_q]} : 8'h00;
  assign ascii_valid = (count_q != '0);
  assign caps_lock   = caps_q;
  assign overflow    = ovf_q;
  assign fifo_level  = count_q;
endmodule

// File: doc/ps2_kbd_ascii.md
Name: ps2_kbd_ascii

Overview:
Downstream consumer of the PS/2 port receiver. Takes set-2 scancode events (scancode, strobe, extended, released) and tracks modifier state (Shift, Ctrl, Caps Lock). Translates make codes to 7-bit ASCII and buffers the characters in a small FIFO. The FIFO drains through a valid/ready handshake into the UART debug text path.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; power of 2, at least 2.
LW, $clog2(FIFO_DEPTH)+1, width of fifo_level (derived localparam, not overridable).

Ports:
clk_25mhz  input  1  system clock, 25 MHz
reset_n  input  1  synchronous, active-low reset
scancode  input  8  set-2 scancode from the PS/2 port
key_valid  input  1  scancode strobe; rising edge detected internally, so level or pulse both work
extended  input  1  E0 prefix seen for this scancode
released  input  1  F0 break prefix seen for this scancode
ascii  output  8  FIFO head character; bit 7 is always 0
ascii_valid  output  1  FIFO not empty
ascii_ready  input  1  consumer accepts the head when ascii_valid && ascii_ready
caps_lock  output  1  Caps Lock state (LED drive)
overflow  output  1  sticky flag: a character was dropped because the FIFO was full
fifo_level  output  LW  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset: synchronous on clk_25mhz when reset_n=0. Reset takes priority over every event in the same cycle.
- Reset clears outputs: ascii=0, ascii_valid=0, caps_lock=0, overflow=0, fifo_level=0.
- Reset clears internal state: shift_l/shift_r/ctrl held=0, caps_held=0, pipeline valids=0, FIFO pointers=0, edge-detect register=0.
- Reset mid-operation discards in-flight events and all FIFO contents.
- Stage S0 (capture): on a key_valid rising edge, register {extended, released, scancode}.
- Stage S1 (lookup): registered ROM lookup gives the unshifted code, the shifted code and an is_letter flag. Modifier codes are decoded here.
- Stage S2 (apply): modifier update, or character select and FIFO push.
- Latency: key_valid edge at cycle N gives ascii_valid=1 at cycle N+3 when the FIFO was empty.
- Back-to-back edges are accepted every 2 cycles; the pipeline never stalls.
- Modifier codes:
  - 0x12 = left Shift, 0x59 = right Shift. shift = shift_l | shift_r.
  - 0x14 = Ctrl, with or without E0; one shared held bit.
  - Make sets the held bit, break clears it. Modifier codes never push a character.
- Caps Lock (0x58):
  - Toggles caps_lock on make only when caps_held=0, then sets caps_held. Break clears caps_held.
  - Typematic repeat makes therefore do not re-toggle.
- Translation, non-extended make codes:
  - Letters 0x1C=a, 0x32=b, 0x21=c … full set-2 alphabet.
  - Digits 0x16='1' … 0x45='0'; shifted forms "!@#$%^&*()".
  - Punctuation: - = [ ] \ ; ' , . / ` with US shifted forms.
  - 0x29 → 0x20 (space), 0x5A → 0x0D (Enter), 0x66 → 0x08 (Backspace), 0x0D → 0x09 (Tab), 0x76 → 0x1B (Esc).
- Translation, extended make codes: only E0 5A (keypad Enter) → 0x0D. E0 4A → '/'.
- Dropped: all other extended codes, all break codes and all unmapped codes. These produce no push and no error.
- Case rule:
  - Letters are uppercase iff shift XOR caps_lock.
  - Non-letters use the shifted code iff shift; caps_lock has no effect on them.
- FIFO behaviour:
  - ascii is the registered head, stable while ascii_valid=1 && ascii_ready=0.
  - Pop when ascii_valid && ascii_ready.
  - Push when full and no pop in the same cycle: the character is dropped, overflow is set and held until reset.
  - Push and pop in the same cycle: both happen, including when full; level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
PS2_KBD_CTRL_CODES_EN
- Defined: a letter with ctrl held pushes its control code, letter&0x1F (Ctrl+A=0x01 … Ctrl+Z=0x1A), regardless of shift and caps. Non-letters with ctrl pass through unchanged.
- Undefined: ctrl state is tracked but ignored, and letters translate normally.

Test Plan:
1. Reset, then edge with scancode=0x1C, released=0 → 3 cycles later ascii_valid=1, ascii=0x61, fifo_level=1. Assert ascii_ready 1 cycle → ascii_valid=0.
2. Send 0x12 make, 0x1C make, 0x16 make, 0x12 break, 0x1C make → FIFO holds 0x41, 0x21, 0x61.
3. Send 0x58 make, 0x58 make (repeat), 0x58 break, then 0x1C and 0x16 makes → caps_lock=1, output 0x41, 0x31. A further 0x58 make/break → caps_lock=0.
4. ascii_ready=0 with 9 letter makes (0x1C) at FIFO_DEPTH=8 → fifo_level=8, overflow=1. Drain gives exactly 8 × 0x61. Simultaneous push/pop at full keeps level=8.
5. Send E0 5A make → 0x0D. Send E0 75 make and 0x1C break → no push.
6. PS2_KBD_CTRL_CODES_EN defined: 0x14 make, 0x21 make → 0x03. Then pulse reset_n=0 for 1 cycle mid-stream → all outputs return to reset values and the next 0x1C gives 0x61.
